// File: rtl/lcd_host_seq_if.sv
// Bundles the system-side request/pixel/result ports and the LCD controller ports of lcd_host_seq.
// master is the sequencer itself; slave is the environment around it (system harness plus LCD).
interface lcd_host_seq_if;
    logic       req_valid;
    logic [2:0] req_cmd;
    logic       req_ready;

    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;

    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] lcd_datain;
    logic       lcd_busy;
    logic [7:0] lcd_dataout;
    logic       lcd_output_valid;

    logic       res_valid;
    logic [7:0] res_data;
    logic       res_last;

    logic       err_timeout;
    logic       err_spurious;

    modport master (
        input  req_valid, req_cmd, pix_valid, pix_data,
        input  lcd_busy, lcd_dataout, lcd_output_valid,
        output req_ready, pix_ready,
        output lcd_cmd, lcd_cmd_valid, lcd_datain,
        output res_valid, res_data, res_last,
        output err_timeout, err_spurious
    );

    modport slave (
        output req_valid, req_cmd, pix_valid, pix_data,
        output lcd_busy, lcd_dataout, lcd_output_valid,
        input  req_ready, pix_ready,
        input  lcd_cmd, lcd_cmd_valid, lcd_datain,
        input  res_valid, res_data, res_last,
        input  err_timeout, err_spurious
    );
endinterface

// File: rtl/lcd_host_seq.sv
// Host-side sequencer for the LCD controller: buffers a frame for load commands, issues the
// command, replays the frame one pixel per cycle and forwards OUT_CNT result pixels.
module lcd_host_seq #(
    parameter int WIDTH   = 12,
    parameter int HEIGHT  = 9,
    parameter int OUT_CNT = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    lcd_host_seq_if.master bus
);
    localparam int FRAME = WIDTH * HEIGHT;
    localparam int PIX_W = $clog2(FRAME);
    localparam int OUT_W = $clog2(OUT_CNT + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        STREAM,
        WAIT_OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]       cmd_q;
    logic [PIX_W-1:0] pcnt;
    logic [PIX_W-1:0] kcnt;
    logic [OUT_W-1:0] ocnt;
    logic [WD_W-1:0]  wd;
    logic [7:0]       frame_buf [FRAME];

    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic       res_last_q;
    logic       err_timeout_q;
    logic       err_spurious_q;

    logic req_accept;
    logic pix_accept;
    logic cmd_accept;
    logic stream_done;
    logic out_accept;
    logic out_final;
    logic wd_expire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_accept  = 1'b0;
        pix_accept  = 1'b0;
        cmd_accept  = 1'b0;
        stream_done = 1'b0;
        out_accept  = 1'b0;
        out_final   = 1'b0;
        wd_expire   = 1'b0;
        case (state)
            IDLE: begin
                req_accept = bus.req_valid;
                if (req_accept) begin
                    state_next = (bus.req_cmd == 3'd0) ? FILL : ISSUE;
                end
            end
            FILL: begin
                pix_accept = bus.pix_valid;
                if (pix_accept && pcnt == PIX_W'(FRAME - 1)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cmd_accept = !bus.lcd_busy;
                if (cmd_accept) begin
                    state_next = (cmd_q == 3'd0) ? STREAM : WAIT_OUT;
                end
            end
            STREAM: begin
                stream_done = (kcnt == PIX_W'(FRAME - 1));
                if (stream_done) begin
                    state_next = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                out_accept = bus.lcd_output_valid;
                out_final  = out_accept && (ocnt == OUT_W'(OUT_CNT - 1));
                wd_expire  = !out_accept && (wd == WD_W'(TIMEOUT - 1));
                if (out_final || wd_expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, result register and sticky error flags share one reset domain with the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q          <= '0;
            pcnt           <= '0;
            kcnt           <= '0;
            ocnt           <= '0;
            wd             <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_last_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            if (req_accept) begin
                cmd_q <= bus.req_cmd;
            end
            if (pix_accept) begin
                pcnt <= (pcnt == PIX_W'(FRAME - 1)) ? '0 : pcnt + 1'b1;
            end
            if (state == STREAM) begin
                kcnt <= stream_done ? '0 : kcnt + 1'b1;
            end
            if (cmd_accept) begin
                ocnt <= '0;
                wd   <= '0;
            end
            if (out_accept) begin
                res_valid_q <= 1'b1;
                res_data_q  <= bus.lcd_dataout;
                res_last_q  <= out_final;
                ocnt        <= out_final ? '0 : ocnt + 1'b1;
                wd          <= '0;
            end else if (state == WAIT_OUT) begin
                if (wd_expire) begin
                    err_timeout_q <= 1'b1;
                    wd            <= '0;
                    ocnt          <= '0;
                end else if (wd != '1) begin
                    wd <= wd + 1'b1;
                end
            end
            if (bus.lcd_output_valid && state != WAIT_OUT) begin
                err_spurious_q <= 1'b1;
            end
        end
    end

    // The frame buffer needs no reset; it is always fully rewritten before it is replayed.
    always_ff @(posedge clk) begin
        if (pix_accept) begin
            frame_buf[pcnt] <= bus.pix_data;
        end
    end

    // req_ready is masked by reset because IDLE is also the state held during reset.
    assign bus.req_ready     = (state == IDLE) && reset;
    assign bus.pix_ready     = (state == FILL);
    assign bus.lcd_cmd_valid = (state == ISSUE);
    assign bus.lcd_cmd       = (state == ISSUE) ? cmd_q : 3'd0;
    assign bus.lcd_datain    = (state == STREAM) ? frame_buf[kcnt] : 8'd0;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_data      = res_data_q;
    assign bus.res_last      = res_last_q;
    assign bus.err_timeout   = err_timeout_q;
    assign bus.err_spurious  = err_spurious_q;
endmodule

// File: tb/tb_lcd_host_seq.sv
// Bench for lcd_host_seq: drives requests and frames, plays a stub LCD controller and checks
// results against a scoreboard of expected pixels.
module tb_lcd_host_seq;
    localparam int W       = 12;
    localparam int H       = 9;
    localparam int FRAME   = W * H;
    localparam int OUT_CNT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk;
    logic reset;
    lcd_host_seq_if bus();

    lcd_host_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];
    logic [7:0] frame_ref [FRAME];
    logic [7:0] lcd_mem   [FRAME];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] time limit exceeded");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic sample_results();
        exp_t e;
        if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("res_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("res_data", bus.res_data, e.data);
                checkOutput("res_last", bus.res_last, e.last);
            end
        end
    endtask

    // Every wait in the bench goes through tick so no result strobe is missed.
    task automatic tick();
        @(negedge clk);
        sample_results();
    endtask

    task automatic check_zero_outputs();
        checkOutput("zero_req_ready", bus.req_ready, 0);
        checkOutput("zero_pix_ready", bus.pix_ready, 0);
        checkOutput("zero_lcd_cmd", bus.lcd_cmd, 0);
        checkOutput("zero_lcd_cmd_valid", bus.lcd_cmd_valid, 0);
        checkOutput("zero_lcd_datain", bus.lcd_datain, 0);
        checkOutput("zero_res_valid", bus.res_valid, 0);
        checkOutput("zero_res_data", bus.res_data, 0);
        checkOutput("zero_res_last", bus.res_last, 0);
        checkOutput("zero_err_timeout", bus.err_timeout, 0);
        checkOutput("zero_err_spurious", bus.err_spurious, 0);
    endtask

    function automatic int out_index(input logic [2:0] cmd, input int j);
        if (cmd == 3'd1) return (3 + j / 4) * W + 4 + (j % 4);
        return (1 + 2 * (j / 4)) * W + 1 + 3 * (j % 4);
    endfunction

    task automatic send_req(input logic [2:0] cmd);
        int n;
        tick();
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput("req_ready_wait", 0, 1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic send_frame();
        int n;
        for (int i = 0; i < FRAME; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = frame_ref[i];
            n = 0;
            while (!bus.pix_ready && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) checkOutput("pix_ready_wait", 0, 1);
            tick();
        end
        bus.pix_valid = 1'b0;
    endtask

    // Stub LCD: accepts the command, captures the stream, then answers with 16 sampled pixels.
    task automatic serve_cmd(input logic [2:0] cmd, input int busy_cycles, input int abort_at);
        exp_t e;
        if (busy_cycles > 0) bus.lcd_busy = 1'b1;
        for (int b = 0; b < busy_cycles; b++) begin
            checkOutput("cmd_valid_busy", bus.lcd_cmd_valid, 1);
            tick();
        end
        bus.lcd_busy = 1'b0;
        checkOutput("cmd_valid", bus.lcd_cmd_valid, 1);
        checkOutput("cmd_code", bus.lcd_cmd, cmd);
        tick();
        checkOutput("cmd_valid_drop", bus.lcd_cmd_valid, 0);
        if (cmd == 3'd0) begin
            for (int k = 0; k < FRAME; k++) begin
                if (k == abort_at) begin
                    reset = 1'b0;
                    #1;
                    check_zero_outputs();
                    tick();
                    reset = 1'b1;
                    return;
                end
                checkOutput("datain", bus.lcd_datain, frame_ref[k]);
                lcd_mem[k] = bus.lcd_datain;
                tick();
            end
            checkOutput("datain_after_stream", bus.lcd_datain, 0);
        end
        if (cmd > 3'd2) return;
        for (int j = 0; j < OUT_CNT; j++) begin
            e.data = frame_ref[out_index(cmd, j)];
            e.last = (j == OUT_CNT - 1);
            exp_q.push_back(e);
        end
        repeat (2) tick();
        for (int j = 0; j < OUT_CNT; j++) begin
            bus.lcd_output_valid = 1'b1;
            bus.lcd_dataout      = lcd_mem[out_index(cmd, j)];
            if (j == OUT_CNT - 1) checkOutput("ready_before_last", bus.req_ready, 0);
            tick();
            if (j % 3 == 1) begin
                bus.lcd_output_valid = 1'b0;
                bus.lcd_dataout      = 8'hEE;
                tick();
            end
        end
        bus.lcd_output_valid = 1'b0;
        bus.lcd_dataout      = 8'h00;
        checkOutput("ready_after_last", bus.req_ready, 1);
        checkOutput("results_pending", exp_q.size(), 0);
    endtask

    initial begin
        reset                = 1'b0;
        bus.req_valid        = 1'b0;
        bus.req_cmd          = 3'd0;
        bus.pix_valid        = 1'b0;
        bus.pix_data         = 8'd0;
        bus.lcd_busy         = 1'b0;
        bus.lcd_dataout      = 8'd0;
        bus.lcd_output_valid = 1'b0;
        repeat (3) tick();
        check_zero_outputs();
        reset = 1'b1;
        tick();
        checkOutput("ready_after_release", bus.req_ready, 1);

        $display("[TB] T1 load with p[i]=i");
        for (int i = 0; i < FRAME; i++) frame_ref[i] = 8'(i);
        send_req(3'd0);
        send_frame();
        checkOutput("pix_ready_issue", bus.pix_ready, 0);
        checkOutput("req_ready_issue", bus.req_ready, 0);
        serve_cmd(3'd0, 0, -1);

        $display("[TB] T2 zoom in");
        send_req(3'd1);
        serve_cmd(3'd1, 0, -1);

        $display("[TB] T3 zoom fit with busy held 5 cycles");
        send_req(3'd2);
        serve_cmd(3'd2, 5, -1);

        $display("[TB] T4 shift with silent LCD");
        send_req(3'd3);
        serve_cmd(3'd3, 0, -1);
        repeat (254) tick();
        checkOutput("timeout_early", bus.err_timeout, 0);
        checkOutput("busy_before_timeout", bus.req_ready, 0);
        tick();
        checkOutput("err_timeout", bus.err_timeout, 1);
        checkOutput("ready_after_timeout", bus.req_ready, 1);

        $display("[TB] T5 spurious output_valid in IDLE");
        tick();
        bus.lcd_dataout      = 8'h5A;
        bus.lcd_output_valid = 1'b1;
        tick();
        bus.lcd_output_valid = 1'b0;
        checkOutput("err_spurious", bus.err_spurious, 1);
        checkOutput("res_valid_spurious", bus.res_valid, 0);
        checkOutput("err_timeout_sticky", bus.err_timeout, 1);
        tick();

        $display("[TB] T6 reset during stream, then fresh load");
        for (int i = 0; i < FRAME; i++) frame_ref[i] = 8'(i ^ 8'h5A);
        send_req(3'd0);
        send_frame();
        serve_cmd(3'd0, 0, 50);
        tick();
        checkOutput("ready_after_abort", bus.req_ready, 1);
        checkOutput("err_timeout_cleared", bus.err_timeout, 0);
        checkOutput("err_spurious_cleared", bus.err_spurious, 0);
        checkOutput("no_results_after_abort", exp_q.size(), 0);
        for (int i = 0; i < FRAME; i++) frame_ref[i] = 8'(i * 3 + 7);
        send_req(3'd0);
        send_frame();
        serve_cmd(3'd0, 0, -1);
        repeat (3) tick();
        checkOutput("final_idle_ready", bus.req_ready, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
